sseg_scan_decoder: RTL and testbench

Passive monitor for the multiplexed 7-segment bus (active-low anodes `an`, active-low segments `sseg[0:6]`). It samples the anode/segment pins, waits for each selected digit to settle, decodes each glyph back to a hex nibble and rebuilds the 16-bit value on the display. It sits on the board pins or in loopback benches next to the display driver, for self-check and readback.

---
 rtl/sseg_scan_decoder_pkg.sv | 53 +++++
 rtl/sseg_to_hex.sv | 38 +++
 rtl/sseg_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan monitor: glyph table, scan FSM
// states and the anode-selection helper.
package sseg_pkg;

    // Segment patterns are sseg[0:6] = a..g, active low.
    localparam logic [0:6] GLYPH_0     = 7'b0000001;
    localparam logic [0:6] GLYPH_1     = 7'b1001111;
    localparam logic [0:6] GLYPH_2     = 7'b0010010;
    localparam logic [0:6] GLYPH_3     = 7'b0000110;
    localparam logic [0:6] GLYPH_4     = 7'b1001100;
    localparam logic [0:6] GLYPH_5     = 7'b0100100;
    localparam logic [0:6] GLYPH_6     = 7'b0100000;
    localparam logic [0:6] GLYPH_7     = 7'b0001111;
    localparam logic [0:6] GLYPH_8     = 7'b0000000;
    localparam logic [0:6] GLYPH_9     = 7'b0000100;
    localparam logic [0:6] GLYPH_A     = 7'b0001000;
    localparam logic [0:6] GLYPH_B     = 7'b1100000;
    localparam logic [0:6] GLYPH_C     = 7'b0110001;
    localparam logic [0:6] GLYPH_D     = 7'b1000010;
    localparam logic [0:6] GLYPH_E     = 7'b0110000;
    localparam logic [0:6] GLYPH_F     = 7'b0111000;
    localparam logic [0:6] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] idx;
    } an_sel_t;

    // Exactly one low anode is a selection; blank or multiple lows are not.
    function automatic an_sel_t decode_an(input logic [3:0] an);
        an_sel_t sel;
        sel.legal = 1'b1;
        sel.idx   = 2'd0;
        case (an)
            4'b1110: sel.idx = 2'd0;
            4'b1101: sel.idx = 2'd1;
            4'b1011: sel.idx = 2'd2;
            4'b0111: sel.idx = 2'd3;
            default: begin
                sel.legal = 1'b0;
                sel.idx   = 2'd0;
            end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational glyph decoder: inverse of the hex-to-segment encoder.
module sseg_to_hex
    import sseg_pkg::*;
(
    input  logic [0:6] sseg,
    output logic       legal,
    output logic [3:0] nibble
);

    // Map each legal glyph back to its nibble; anything else is flagged.
    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (sseg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: begin
                legal  = 1'b0;
                nibble = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Passive monitor of a multiplexed 7-segment bus: waits for each selected
// digit to settle, decodes it and rebuilds the displayed 16-bit value.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int         SETTLE_CYCLES  = 4,
    parameter int         TIMEOUT_CYCLES = 1048576,
    parameter logic [3:0] DIGIT_MASK     = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:6]  sseg,
    input  logic [3:0]  an,
    output logic [15:0] num,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        glyph_err,
    output logic        timeout
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

    logic [3:0]    an_m_r, an_s_r;
    logic [0:6]    sseg_m_r, sseg_s_r;
    logic [10:0]   prev_r;
    logic [10:0]   cur_s;
    logic          changed_s;
    an_sel_t       sel_s;
    logic          glyph_ok_s;
    logic [3:0]    nibble_s;
    scan_state_t   state_r, state_nx_s;
    logic [SW-1:0] scnt_r, scnt_nx_s, scnt_inc_s;
    logic [TW-1:0] tcnt_r, tcnt_inc_s;
    logic          capture_s, expire_s, frame_hit_s;
    logic [3:0]    seen_r, seen_set_s;
    logic [15:0]   num_r;
    logic [3:0]    dv_r;
    logic          frame_r, gerr_r, tmo_r;

    // Two-flop synchronizers plus one delayed copy for change detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_m_r   <= 4'hF;
            an_s_r   <= 4'hF;
            sseg_m_r <= 7'h7F;
            sseg_s_r <= 7'h7F;
            prev_r   <= 11'h7FF;
        end else begin
            an_m_r   <= an;
            an_s_r   <= an_m_r;
            sseg_m_r <= sseg;
            sseg_s_r <= sseg_m_r;
            prev_r   <= cur_s;
        end
    end

    assign cur_s      = {an_s_r, sseg_s_r};
    assign changed_s  = (cur_s != prev_r);
    assign sel_s      = decode_an(an_s_r);
    assign scnt_inc_s = scnt_r + SW'(1);
    assign tcnt_inc_s = tcnt_r + TW'(1);
    assign seen_set_s = seen_r | (4'b0001 << sel_s.idx);
    assign frame_hit_s = ((seen_set_s & DIGIT_MASK) == DIGIT_MASK);
    assign expire_s   = !capture_s && (tcnt_inc_s == TMO_MAX);

    sseg_to_hex u_dec (
        .sseg   (sseg_s_r),
        .legal  (glyph_ok_s),
        .nibble (nibble_s)
    );

    // Scan FSM next state: a change always restarts the settle count at 1.
    always_comb begin
        state_nx_s = state_r;
        scnt_nx_s  = scnt_r;
        capture_s  = 1'b0;
        if (!sel_s.legal) begin
            state_nx_s = ST_IDLE;
            scnt_nx_s  = '0;
        end else if (changed_s || (state_r == ST_IDLE)) begin
            scnt_nx_s = SW'(1);
            if (SETTLE_MAX == SW'(1)) begin
                capture_s  = 1'b1;
                state_nx_s = ST_HELD;
            end else begin
                state_nx_s = ST_SETTLE;
            end
        end else begin
            case (state_r)
                ST_SETTLE: begin
                    scnt_nx_s = scnt_inc_s;
                    if (scnt_inc_s == SETTLE_MAX) begin
                        capture_s  = 1'b1;
                        state_nx_s = ST_HELD;
                    end else begin
                        state_nx_s = ST_SETTLE;
                    end
                end
                ST_HELD: state_nx_s = ST_HELD;
                default: begin
                    state_nx_s = ST_IDLE;
                    scnt_nx_s  = '0;
                end
            endcase
        end
    end

    // FSM state and settle counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            scnt_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            scnt_r  <= scnt_nx_s;
        end
    end

    // Capture, frame tracking and timeout; a capture pre-empts expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_r   <= 16'h0000;
            dv_r    <= 4'b0000;
            seen_r  <= 4'b0000;
            tcnt_r  <= '0;
            frame_r <= 1'b0;
            gerr_r  <= 1'b0;
            tmo_r   <= 1'b0;
        end else begin
            frame_r <= 1'b0;
            gerr_r  <= 1'b0;
            tmo_r   <= 1'b0;
            if (capture_s) begin
                tcnt_r <= '0;
                if (glyph_ok_s) begin
                    num_r[{sel_s.idx, 2'b00} +: 4] <= nibble_s;
                    dv_r[sel_s.idx] <= 1'b1;
                    if (frame_hit_s) begin
                        frame_r <= 1'b1;
                        seen_r  <= 4'b0000;
                    end else begin
                        seen_r  <= seen_set_s;
                    end
                end else begin
                    gerr_r <= 1'b1;
                    dv_r[sel_s.idx]   <= 1'b0;
                    seen_r[sel_s.idx] <= 1'b0;
                end
            end else if (expire_s) begin
                tmo_r  <= 1'b1;
                dv_r   <= 4'b0000;
                seen_r <= 4'b0000;
                tcnt_r <= '0;
            end else begin
                tcnt_r <= tcnt_inc_s;
            end
        end
    end

    assign num         = num_r;
    assign digit_valid = dv_r;
    assign frame_valid = frame_r;
    assign glyph_err   = gerr_r;
    assign timeout     = tmo_r;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: full and partial digit masks share
// the same pin stimulus.
module tb_sseg_scan_decoder;

    localparam logic [0:6] S_1 = 7'b1001111;
    localparam logic [0:6] S_2 = 7'b0010010;
    localparam logic [0:6] S_3 = 7'b0000110;
    localparam logic [0:6] S_4 = 7'b1001100;
    localparam logic [0:6] S_5 = 7'b0100100;
    localparam logic [0:6] S_7 = 7'b0001111;
    localparam logic [0:6] S_8 = 7'b0000000;
    localparam logic [0:6] S_A = 7'b0001000;
    localparam logic [0:6] S_B = 7'b1100000;
    localparam logic [0:6] S_C = 7'b0110001;
    localparam logic [0:6] S_E = 7'b0110000;
    localparam logic [0:6] S_X = 7'b1111110;
    localparam logic [0:6] S_BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:6]  sseg = 7'b1111111;
    logic [3:0]  an = 4'b1111;
    logic [15:0] num, num_m;
    logic [3:0]  dv, dv_m;
    logic        fv, fv_m, gerr, gerr_m, tmo, tmo_m;

    int n_cmp = 0;
    int n_err = 0;
    int fcnt = 0, fcnt_m = 0, gcnt = 0, tcnt = 0;
    int f0, fm0, g0, t0;
    logic [15:0] fsnap = 16'h0000, fsnap_m = 16'h0000;
    logic [3:0]  an_v;
    bit got_tmo;

    always #5 clk = ~clk;

    sseg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(400), .DIGIT_MASK(4'b1111)) dut (
        .clk(clk), .rst(rst), .sseg(sseg), .an(an), .num(num), .digit_valid(dv),
        .frame_valid(fv), .glyph_err(gerr), .timeout(tmo)
    );

    sseg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(400), .DIGIT_MASK(4'b0111)) dut_m (
        .clk(clk), .rst(rst), .sseg(sseg), .an(an), .num(num_m), .digit_valid(dv_m),
        .frame_valid(fv_m), .glyph_err(gerr_m), .timeout(tmo_m)
    );

    // Pulse counters and value snapshots, sampled on the inactive edge.
    always @(negedge clk) begin
        if (fv) begin
            fcnt++;
            fsnap = num;
        end
        if (fv_m) begin
            fcnt_m++;
            fsnap_m = num_m;
        end
        if (gerr) gcnt++;
        if (tmo) tcnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply pins just after an edge and hold them for n clock edges.
    task automatic drive(input logic [3:0] a, input logic [0:6] s, input int n);
        an   = a;
        sseg = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2;
        check_eq("rst_num", 32'(num), 32'h0);
        check_eq("rst_dv", 32'(dv), 32'h0);
        check_eq("rst_pulses", 32'({fv, gerr, tmo}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(4'b1111, S_BLANK, 3);

        // Scan 4,3,2,1 on digits 0..3 with exact latency on the first one.
        drive(4'b1110, S_4, 5);
        check_eq("lat_before", 32'(dv), 32'h0);
        drive(4'b1110, S_4, 1);
        check_eq("lat_dv", 32'(dv), 32'h1);
        check_eq("lat_num", 32'(num), 32'h0004);
        drive(4'b1110, S_4, 4);
        drive(4'b1101, S_3, 10);
        drive(4'b1011, S_2, 10);
        drive(4'b0111, S_1, 10);
        drive(4'b1111, S_BLANK, 10);
        check_eq("scan_num", 32'(num), 32'h1234);
        check_eq("scan_dv", 32'(dv), 32'hF);
        check_eq("scan_frames", 32'(fcnt), 32'd1);
        check_eq("scan_frame_at", 32'(fsnap), 32'h1234);
        check_eq("mask_frames1", 32'(fcnt_m), 32'd1);
        check_eq("mask_frame_at", 32'(fsnap_m), 32'h0234);

        // Three rounds of A,b,C on digits 0..2 only.
        f0 = fcnt; fm0 = fcnt_m;
        for (int r = 0; r < 3; r++) begin
            drive(4'b1110, S_A, 8);
            drive(4'b1101, S_B, 8);
            drive(4'b1011, S_C, 8);
        end
        drive(4'b1111, S_BLANK, 10);
        check_eq("mask_num", 32'(num_m[11:0]), 32'hCBA);
        check_eq("mask_frames", 32'(fcnt_m - fm0), 32'd3);
        check_eq("full_no_frame", 32'(fcnt - f0), 32'd0);
        check_eq("full_num", 32'(num), 32'h1CBA);

        // Glitch mid-settle: only the final glyph lands, after a full settle.
        g0 = gcnt;
        drive(4'b1101, S_5, 2);
        drive(4'b1101, S_8, 2);
        drive(4'b1101, S_7, 5);
        check_eq("glitch_wait", 32'(num[7:4]), 32'hB);
        drive(4'b1101, S_7, 1);
        check_eq("glitch_num", 32'(num[7:4]), 32'h7);
        drive(4'b1101, S_7, 4);
        drive(4'b1111, S_BLANK, 10);
        check_eq("glitch_noerr", 32'(gcnt - g0), 32'd0);

        // Illegal pattern on digit 1.
        g0 = gcnt; f0 = fcnt;
        drive(4'b1101, S_X, 10);
        drive(4'b1111, S_BLANK, 10);
        check_eq("ill_err", 32'(gcnt - g0), 32'd1);
        check_eq("ill_dv1", 32'(dv[1]), 32'h0);
        check_eq("ill_num", 32'(num[7:4]), 32'h7);
        check_eq("ill_dv", 32'(dv), 32'hD);
        check_eq("ill_noframe", 32'(fcnt - f0), 32'd0);

        // No selection: two anodes low, then all blank.
        g0 = gcnt; f0 = fcnt; t0 = tcnt;
        drive(4'b1100, S_8, 100);
        drive(4'b1111, S_8, 100);
        check_eq("nosel_num", 32'(num), 32'h1C7A);
        check_eq("nosel_pulses", 32'((gcnt - g0) + (fcnt - f0) + (tcnt - t0)), 32'd0);
        check_eq("nosel_dv", 32'(dv), 32'hD);

        // Static pins: wait for the timeout with a bounded loop.
        got_tmo = 1'b0;
        for (int i = 0; i < 500 && !got_tmo; i++) begin
            @(posedge clk); #1;
            if (tcnt != t0) got_tmo = 1'b1;
        end
        check_eq("tmo_seen", 32'(got_tmo), 32'h1);
        check_eq("tmo_count", 32'(tcnt - t0), 32'd1);
        check_eq("tmo_dv", 32'(dv), 32'h0);
        check_eq("tmo_num", 32'(num), 32'h1C7A);

        // Reset during SETTLE, then hold the input across release.
        drive(4'b1011, S_E, 4);
        rst = 1'b0;
        #1;
        check_eq("arst_num", 32'(num), 32'h0);
        check_eq("arst_dv", 32'(dv), 32'h0);
        check_eq("arst_pulses", 32'({fv, gerr, tmo}), 32'h0);
        an_v = an;
        drive(an_v, S_E, 2);
        rst = 1'b1;
        drive(an_v, S_E, 5);
        check_eq("rel_wait", 32'(dv), 32'h0);
        drive(an_v, S_E, 1);
        check_eq("rel_dv", 32'(dv), 32'h4);
        check_eq("rel_num", 32'(num), 32'h0E00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
